// File: rtl/mc_control_unit.sv
// Multicycle ARM-subset control unit.
// Sequences fetch/decode/execute/memory/writeback through a two-process FSM,
// decodes the ALU command, keeps the NZCV flag register, evaluates condition
// codes and watches memory handshakes for a timeout.
// Ports:
//   clk, Reset          clock, synchronous active-high reset
//   Cond, ALUFlags      instruction condition field, {N,Z,C,V} from the ALU
//   Op, Funct, Rd       instruction class, bits [25:20], destination register
//   MemReady            memory finishes the current access this cycle
//   PCWrite, RegWrite, MemWrite, IRWrite   write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc   datapath selects
//   ALUCtrl             ALU operation (width ALUCTRL_W, 3 adds EOR)
//   MemReq              memory access request
//   Fault               sticky fault (undefined instruction or memory timeout)
module mc_control_unit #(
  parameter int unsigned ALUCTRL_W = 2,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [3:0]           Cond,
  input  logic [3:0]           ALUFlags,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUCtrl,
  output logic                 MemReq,
  output logic                 Fault
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECR, EXECI, ALUWB, BRANCH, FAULT
  } state_t;

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t               state, next_state;
  logic [3:0]           flags;      // {N,Z,C,V}
  logic                 cond_ex, cond_ex_r;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 timeout;
  logic [ALUCTRL_W-1:0] alu_dec;
  logic                 alu_ok, arith, no_write;

  assign ImmSrc  = Op;
  assign RegSrc  = {Op == 2'b01, Op == 2'b10};
  assign timeout = (wait_cnt == CNT_W'(TIMEOUT));

  // Condition evaluation against the stored flags
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags;
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // ALU command decode from Funct[4:1]
  always_comb begin
    alu_dec  = '0;
    alu_ok   = 1'b1;
    arith    = 1'b0;
    no_write = 1'b0;
    case (Funct[4:1])
      4'b0100: begin alu_dec = ALUCTRL_W'(2'b00); arith = 1'b1; end
      4'b0010: begin alu_dec = ALUCTRL_W'(2'b01); arith = 1'b1; end
      4'b0000: alu_dec = ALUCTRL_W'(2'b10);
      4'b1100: alu_dec = ALUCTRL_W'(2'b11);
      4'b1010: begin alu_dec = ALUCTRL_W'(2'b01); arith = 1'b1; no_write = 1'b1; end
      4'b0001: begin
        if (ALUCTRL_W == 3) alu_dec = ALUCTRL_W'(3'b100);
        else                alu_ok  = 1'b0;
      end
      default: alu_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUCtrl    = '0;
    MemReq     = 1'b0;
    Fault      = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        MemReq    = 1'b1;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   next_state = MEMADR;
          2'b00:   next_state = !alu_ok ? FAULT : (Funct[5] ? EXECI : EXECR);
          2'b10:   next_state = BRANCH;
          default: next_state = FAULT;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        next_state = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        MemReq = 1'b1;
        if (MemReady) next_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = cond_ex_r;
        next_state = FETCH;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemReq   = 1'b1;
        MemWrite = cond_ex_r;
        if (MemReady) next_state = FETCH;
      end
      EXECR: begin
        ALUCtrl    = alu_dec;
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUCtrl    = alu_dec;
        next_state = ALUWB;
      end
      ALUWB: begin
        RegWrite   = cond_ex_r & ~no_write;
        PCWrite    = cond_ex_r & (Rd == 4'd15) & ~no_write;
        next_state = FETCH;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCWrite    = cond_ex_r;
        next_state = FETCH;
      end
      FAULT:   Fault = 1'b1;
      default: next_state = FAULT;
    endcase
    // A timed-out access must not complete: override the transition and any write
    if (timeout) begin
      next_state = FAULT;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
    end
    if (Reset) begin
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

  // Counts consecutive stalled cycles within one memory-access state
  always_ff @(posedge clk) begin
    if (Reset || MemReady || (next_state != state)) wait_cnt <= '0;
    else if (MemReq)                                 wait_cnt <= wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (Reset)                    cond_ex_r <= 1'b0;
    else if (state == DECODE)     cond_ex_r <= cond_ex;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      flags <= '0;
    end else if ((state == EXECR || state == EXECI) && cond_ex_r) begin
      if (Funct[0])         flags[3:2] <= ALUFlags[3:2];
      if (Funct[0] & arith) flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter ALUCTRL_W, default 2, ALUCtrl width; legal values are 2 and 3, where 3 enables EOR.
REQ-002 Parameter TIMEOUT, default 15, number of consecutive MemReady=0 wait cycles before Fault.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Cond  in  4  instruction condition field.
REQ-006 ALUFlags  in  4  {N,Z,C,V} from ALU.
REQ-007 Op  in  2  instruction class.
REQ-008 Funct  in  6  instruction bits [25:20].
REQ-009 Rd  in  4  destination register.
REQ-010 MemReady  in  1  memory completes the current access this cycle.
REQ-011 PCWrite, RegWrite, MemWrite, IRWrite  out  1 each  write enables.
REQ-012 AdrSrc, ALUSrcA  out  1 each  mux selects.
REQ-013 ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2 each  mux selects.
REQ-014 ALUCtrl  out  ALUCTRL_W  ALU operation.
REQ-015 MemReq  out  1  memory access request.
REQ-016 Fault  out  1  sticky fault, for undefined instruction or memory timeout.

Function
REQ-017 FSM states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH and FAULT; unlisted selects are 0.
REQ-018 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUCtrl=ADD, ResultSrc=10, MemReq=1; IRWrite=PCWrite=1 only when MemReady=1; transition to DECODE only when MemReady=1.
REQ-019 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; next state: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 or an unsupported ALU command -> FAULT.
REQ-020 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUCtrl=ADD; next state is MEMRD if Funct[0]=1, otherwise MEMWR.
REQ-021 MEMRD: AdrSrc=1, MemReq=1; transition to MEMWB when MemReady=1; otherwise hold.
REQ-022 MEMWB: ResultSrc=01, RegWrite=CondExR; next state FETCH.
REQ-023 MEMWR: AdrSrc=1, MemReq=1, MemWrite=CondExR held every cycle; transition to FETCH when MemReady=1.
REQ-024 EXECR uses ALUSrcB=00 and EXECI uses ALUSrcB=01; both use ALUSrcA=0 and the decoded ALUCtrl, and both go to ALUWB.
REQ-025 ALUWB: ResultSrc=00, RegWrite=CondExR & ~NoWrite, PCWrite=CondExR & (Rd==15) & ~NoWrite; next state FETCH.
REQ-026 BRANCH: ALUSrcA=0, ALUSrcB=01, ALUCtrl=ADD, ResultSrc=10, PCWrite=CondExR; next state FETCH.
REQ-027 ALU decode uses cmd=Funct[4:1] with these codes:
  - 0100 ADD=00; 0010 SUB=01; 0000 AND=10; 1100 ORR=11; 1010 CMP=SUB with NoWrite=1.
  - 0001 EOR=100, only when ALUCTRL_W=3.
  - Every other cmd is unsupported.
  - For ALUCTRL_W=3, the 2-bit codes are zero-extended.
REQ-028 FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ADD|SUB|CMP); applies only in EXECR/EXECI.
REQ-029 Flag register {N,Z} SHALL load ALUFlags[3:2] at the end of EXECR/EXECI when FlagW[1] & CondExR; {C,V} SHALL load ALUFlags[1:0] when FlagW[0] & CondExR.
REQ-030 CondEx SHALL be evaluated from Cond and the flag register using standard ARM codes 0000..1110; 1111 evaluates to 0.
REQ-031 CondExR SHALL capture CondEx at the end of DECODE and gate all later writes of that instruction.
REQ-032 ImmSrc=Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01); these are combinational in every state.
REQ-033 The wait counter SHALL increment on each cycle with MemReq=1 and MemReady=0, and clear on MemReady=1 or on any state change.
REQ-034 When the wait counter reaches TIMEOUT, the next state SHALL be FAULT and no write SHALL occur that cycle.
REQ-035 FAULT: all write enables and MemReq are 0, Fault=1, and the state holds until Reset.

Reset
REQ-036 While Reset=1, all write enables SHALL be forced to 0.
REQ-037 On the edge with Reset=1: state=FETCH, flags=0000, CondExR=0, wait counter=0, Fault=0.
REQ-038 Reset asserted in any state, including a stalled memory access or FAULT, SHALL take effect on the next edge with no partial write.

Verification
REQ-039 ADD R1 (Op=00, Funct=001000, Cond=1110), MemReady=1 -> FETCH,DECODE,EXECR,ALUWB; RegWrite=1 in ALUWB only; 4 cycles.
REQ-040 LDR (Op=01, Funct[0]=1) with MemReady low for 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with RegWrite=1.
REQ-041 CMP setting Z=1, then BEQ (Cond=0000) -> PCWrite=1 in BRANCH; a following BNE (0001) -> PCWrite=0 and FETCH follows.
REQ-042 STR with Cond=0001 while Z=1 -> MemWrite=0 throughout MEMWR; returns to FETCH.
REQ-043 EOR cmd=0001 -> with ALUCTRL_W=2: FAULT, Fault=1 sticky until Reset; with ALUCTRL_W=3: ALUCtrl=100.
REQ-044 MemReady held 0 in FETCH for 15 cycles -> FAULT, IRWrite never 1; then Reset -> FETCH with Fault=0.
